// File: rtl/usb4_prbs_pkg.sv
// Shared PRBS11 constants and checker state encoding
// for the Gen4 ordered-set sender/checker pair.
package usb4_prbs_pkg;

  localparam logic [10:0] PRBS11_SEED_L0 = 11'h7FF;
  localparam logic [10:0] PRBS11_SEED_L1 = 11'h770;

  localparam int PRBS11_TAP_HI = 10;
  localparam int PRBS11_TAP_LO = 8;

  localparam int G4_OS_BITS = 448;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    CHECK
  } state_e;

endpackage

// File: rtl/prbs11_predict.sv
// PRBS11 window: shifts either received bits (hunt)
// or its own predicted bits (check).
module prbs11_predict
  import usb4_prbs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic        i_use_pred,
  input  logic        i_bit,
  output logic        o_pred,
  output logic [10:0] o_win_nxt
);

  logic [10:0] r_win;
  logic        w_in;

  assign o_pred = r_win[PRBS11_TAP_HI]
                ^ r_win[PRBS11_TAP_LO];

  assign w_in = i_use_pred ? o_pred : i_bit;

  assign o_win_nxt = {r_win[9:0], w_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (i_clr) begin
      r_win <= '0;
    end else if (i_shift) begin
      r_win <= o_win_nxt;
    end
  end

endmodule

// File: rtl/prbs11_g4_check.sv
// Gen4 PRBS11 receive checker: seed hunt, lock,
// 448-bit ordered-set framing and error counting.
module prbs11_g4_check
  import usb4_prbs_pkg::*;
#(
  parameter bit lane0_lane1 = 1'b1,
  parameter int ERR_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        data_in,
  output logic        locked,
  output logic        bit_err,
  output logic        os_received,
  output logic        os_error,
  output logic [15:0] err_cnt
);

  localparam logic [10:0] SEED =
    lane0_lane1 ? PRBS11_SEED_L0 : PRBS11_SEED_L1;
  localparam logic [8:0] LAST_IDX =
    9'(G4_OS_BITS - 1);
  localparam logic [8:0] LOCK_IDX = 9'd11;
  localparam logic [2:0] LIMIT = 3'(ERR_LIMIT);

  state_e      r_state;
  state_e      w_nxt_state;
  logic        r_locked;
  logic        r_bit_err;
  logic        r_os_rx;
  logic        r_os_err;
  logic [8:0]  r_bit_idx;
  logic [2:0]  r_blk_err;
  logic [15:0] r_err_cnt;

  logic [8:0]  w_nxt_idx;
  logic [2:0]  w_nxt_blk;
  logic [15:0] w_nxt_cnt;
  logic        w_nxt_be;
  logic        w_nxt_osr;
  logic        w_nxt_ose;

  logic        w_clr;
  logic        w_shift;
  logic        w_use_pred;
  logic        w_pred;
  logic [10:0] w_win_nxt;

  logic        w_mis;
  logic [2:0]  w_blk_inc;
  logic        w_end;
  logic        w_off;
  logic        w_hunt;
  logic        w_drop;
  logic        w_chk;

  prbs11_predict u_pred (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (w_clr),
    .i_shift    (w_shift),
    .i_use_pred (w_use_pred),
    .i_bit      (data_in),
    .o_pred     (w_pred),
    .o_win_nxt  (w_win_nxt)
  );

  assign w_mis = data_in ^ w_pred;
  assign w_end = (r_bit_idx == LAST_IDX);

  assign w_blk_inc = (r_blk_err == 3'd7)
                   ? 3'd7
                   : r_blk_err + {2'b00, w_mis};

  // Exactly one of these holds every cycle.
  assign w_off  = !enable;
  assign w_hunt = enable && (r_state != CHECK);
  assign w_drop = enable && (r_state == CHECK)
               && (r_blk_err >= LIMIT);
  assign w_chk  = enable && (r_state == CHECK)
               && (r_blk_err < LIMIT);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_bit_idx;
    w_nxt_blk   = r_blk_err;
    w_nxt_cnt   = r_err_cnt;
    w_nxt_be    = 1'b0;
    w_nxt_osr   = 1'b0;
    w_nxt_ose   = 1'b0;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_use_pred  = 1'b0;
    unique case (1'b1)
      w_off: begin
        w_nxt_state = IDLE;
        w_nxt_idx   = '0;
        w_nxt_blk   = '0;
        w_nxt_cnt   = '0;
        w_clr       = 1'b1;
      end
      w_hunt: begin
        w_shift     = 1'b1;
        w_nxt_state = HUNT;
        if (w_win_nxt == SEED) begin
          w_nxt_state = CHECK;
          w_nxt_idx   = LOCK_IDX;
          w_nxt_blk   = '0;
          w_nxt_cnt   = '0;
        end
      end
      w_drop: begin
        w_nxt_state = HUNT;
        w_clr       = 1'b1;
        w_nxt_idx   = '0;
        w_nxt_blk   = '0;
      end
      w_chk: begin
        w_shift    = 1'b1;
        w_use_pred = 1'b1;
        w_nxt_be   = w_mis;
        if (w_mis && (r_err_cnt != 16'hFFFF)) begin
          w_nxt_cnt = r_err_cnt + 16'd1;
        end
        if (w_end) begin
          w_nxt_idx = '0;
          // A set that hits the limit on its last bit
          // keeps its count so the drop happens next.
          if (w_blk_inc >= LIMIT) begin
            w_nxt_blk = w_blk_inc;
          end else begin
            w_nxt_blk = '0;
            w_nxt_osr = (w_blk_inc == 3'd0);
            w_nxt_ose = (w_blk_inc != 3'd0);
          end
        end else begin
          w_nxt_idx = r_bit_idx + 9'd1;
          w_nxt_blk = w_blk_inc;
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_locked  <= 1'b0;
      r_bit_err <= 1'b0;
      r_os_rx   <= 1'b0;
      r_os_err  <= 1'b0;
      r_bit_idx <= '0;
      r_blk_err <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_locked  <= (w_nxt_state == CHECK);
      r_bit_err <= w_nxt_be;
      r_os_rx   <= w_nxt_osr;
      r_os_err  <= w_nxt_ose;
      r_bit_idx <= w_nxt_idx;
      r_blk_err <= w_nxt_blk;
      r_err_cnt <= w_nxt_cnt;
    end
  end

  assign locked      = r_locked;
  assign bit_err     = r_bit_err;
  assign os_received = r_os_rx;
  assign os_error    = r_os_err;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_prbs11_g4_check.sv
// Directed bench for prbs11_g4_check: checkpoint
// table over a long lane-0 stream plus corner cases.
module tb_prbs11_g4_check;
  import usb4_prbs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en0, din0, en1, din1;
  logic        lk0, be0, osr0, ose0;
  logic        lk1, be1, osr1, ose1;
  logic [15:0] ec0, ec1;

  prbs11_g4_check #(
    .lane0_lane1 (1'b1),
    .ERR_LIMIT   (4)
  ) dut0 (
    .clk         (clk),
    .reset       (rst_n),
    .enable      (en0),
    .data_in     (din0),
    .locked      (lk0),
    .bit_err     (be0),
    .os_received (osr0),
    .os_error    (ose0),
    .err_cnt     (ec0)
  );

  prbs11_g4_check #(
    .lane0_lane1 (1'b0),
    .ERR_LIMIT   (4)
  ) dut1 (
    .clk         (clk),
    .reset       (rst_n),
    .enable      (en1),
    .data_in     (din1),
    .locked      (lk1),
    .bit_err     (be1),
    .os_received (osr1),
    .os_error    (ose1),
    .err_cnt     (ec1)
  );

  typedef struct {
    int          k;
    logic        lk;
    logic        be;
    logic        osr;
    logic        ose;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_bad;
  logic s0[0:4399];
  logic s1[0:499];
  logic st1[0:479];

  task automatic chk(input string nm, input int k,
                     input logic [19:0] got,
                     input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s k=%0d got=%h want=%h",
                 nm, k, got, exp);
    end
  endtask

  function automatic logic flip(input int k);
    return (k == 996)  || (k == 1802) ||
           (k == 1812) || (k == 1822) ||
           (k == 1832) || (k == 4200);
  endfunction

  function automatic logic [19:0] pk0();
    return {lk0, be0, osr0, ose0, ec0};
  endfunction

  function automatic logic [19:0] pk1();
    return {lk1, be1, osr1, ose1, ec1};
  endfunction

  initial begin
    logic [10:0] sd;
    logic [10:0] w;
    logic        bad_pre;
    logic        e_lk, e_be, e_osr, e_ose;
    int          ti;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    en0   = 1'b1;
    din0  = 1'b0;
    en1   = 1'b0;
    din1  = 1'b0;

    // Sender model: seed MSB first, then x^11+x^9+1.
    sd = PRBS11_SEED_L0;
    for (int i = 0; i < 11; i++) s0[i] = sd[10-i];
    for (int i = 11; i < 4400; i++)
      s0[i] = s0[i-11] ^ s0[i-9];
    sd = PRBS11_SEED_L1;
    for (int i = 0; i < 11; i++) s1[i] = sd[10-i];
    for (int i = 11; i < 500; i++)
      s1[i] = s1[i-11] ^ s1[i-9];

    tbl.push_back('{9,    0, 0, 0, 0, 16'd0});
    tbl.push_back('{10,   1, 0, 0, 0, 16'd0});
    tbl.push_back('{446,  1, 0, 0, 0, 16'd0});
    tbl.push_back('{447,  1, 0, 1, 0, 16'd0});
    tbl.push_back('{448,  1, 0, 0, 0, 16'd0});
    tbl.push_back('{895,  1, 0, 1, 0, 16'd0});
    tbl.push_back('{996,  1, 1, 0, 0, 16'd1});
    tbl.push_back('{997,  1, 0, 0, 0, 16'd1});
    tbl.push_back('{1343, 1, 0, 0, 1, 16'd1});
    tbl.push_back('{1791, 1, 0, 1, 0, 16'd1});
    tbl.push_back('{1822, 1, 1, 0, 0, 16'd4});
    tbl.push_back('{1832, 1, 1, 0, 0, 16'd5});
    tbl.push_back('{1833, 0, 0, 0, 0, 16'd5});
    tbl.push_back('{2056, 0, 0, 0, 0, 16'd5});
    tbl.push_back('{2057, 1, 0, 0, 0, 16'd0});
    tbl.push_back('{2494, 1, 0, 1, 0, 16'd0});
    tbl.push_back('{2599, 1, 0, 0, 0, 16'd0});
    tbl.push_back('{2600, 0, 0, 0, 0, 16'd0});
    tbl.push_back('{2602, 0, 0, 0, 0, 16'd0});
    tbl.push_back('{4103, 0, 0, 0, 0, 16'd0});
    tbl.push_back('{4104, 1, 0, 0, 0, 16'd0});
    tbl.push_back('{4200, 1, 1, 0, 0, 16'd1});

    repeat (3) @(posedge clk);
    #1;
    chk("reset0", 0, pk0(), 20'h0);
    chk("reset1", 0, pk1(), 20'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Long lane-0 run: lock, errors, drop, relock, idle.
    ti = 0;
    for (int k = 0; k <= 4300; k++) begin
      en0  = !((k >= 2600) && (k <= 2602));
      din0 = s0[k] ^ flip(k);
      @(posedge clk);
      #1;
      e_lk  = ((k >= 10)   && (k < 1833)) ||
              ((k >= 2057) && (k < 2600)) ||
              (k >= 4104);
      e_be  = flip(k);
      e_osr = (k == 447)  || (k == 895) ||
              (k == 1791) || (k == 2494);
      e_ose = (k == 1343);
      chk("flags", k, {16'h0, lk0, be0, osr0, ose0},
          {16'h0, e_lk, e_be, e_osr, e_ose});
      if ((ti < tbl.size()) && (tbl[ti].k == k)) begin
        chk("table", k, pk0(),
            {tbl[ti].lk, tbl[ti].be, tbl[ti].osr,
             tbl[ti].ose, tbl[ti].ec});
        ti++;
      end
    end

    // Asynchronous reset mid-cycle while locked.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4301, pk0(), 20'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en0   = 1'b1;

    for (int k = 0; k <= 448; k++) begin
      din0 = s0[k];
      @(posedge clk);
      #1;
      chk("restart", k, pk0(),
          {(k >= 10), 1'b0, (k == 447), 1'b0, 16'h0});
    end

    // Lane 1: random prefix, no false lock, then seed.
    do begin
      for (int i = 0; i < 20; i++)
        st1[i] = 1'($urandom_range(1, 0));
      for (int i = 0; i < 460; i++) st1[20+i] = s1[i];
      bad_pre = 1'b0;
      for (int e = 10; e < 30; e++) begin
        for (int b = 0; b < 11; b++)
          w[10-b] = st1[e-10+b];
        if (w == PRBS11_SEED_L1) bad_pre = 1'b1;
      end
    end while (bad_pre);

    @(negedge clk);
    en1 = 1'b1;
    for (int j = 0; j < 470; j++) begin
      din1 = st1[j];
      @(posedge clk);
      #1;
      chk("lane1", j, pk1(),
          {(j >= 30), 1'b0, (j == 467), 1'b0, 16'h0});
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
